// File: rtl/cond_pkg.sv
// Shared encodings for branch condition evaluation and the flush sequencer.
// Flag order everywhere is {N,Z,C,V}.
package cond_pkg;

   localparam logic [1:0] COND_EQ  = 2'b00;
   localparam logic [1:0] COND_UND = 2'b01;
   localparam logic [1:0] COND_GT  = 2'b10;
   localparam logic [1:0] COND_AL  = 2'b11;

   localparam logic [3:0] BRANCH_CLASS = 4'b0011;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition resolver: opcode plus current flags give
// taken / undefined-condition indications.
module cond_eval
   import cond_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic       i_flag_n,
   input  logic       i_flag_z,
   input  logic       i_flag_v,
   output logic       o_taken,
   output logic       o_undef
);

   always_comb begin
      o_taken = 1'b1;
      o_undef = 1'b0;
      // Opcodes outside the conditional class behave as branch-always.
      if (i_opcode[5:2] == BRANCH_CLASS) begin
         case (i_opcode[1:0])
            COND_EQ:  o_taken = i_flag_z;
            COND_UND: begin
               o_taken = 1'b0;
               o_undef = 1'b1;
            end
            COND_GT:  o_taken = ~i_flag_z & (i_flag_n == i_flag_v);
            default:  o_taken = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/branch_flag_controller.sv
// Execute-stage flag register, branch resolution, front-end flush sequencer
// and saturating taken/not-taken performance counters.
module branch_flag_controller
   import cond_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             StallE,
   input  logic             ValidE,
   input  logic             BranchE,
   input  logic             FlagWriteE,
   input  logic [5:0]       OpcodeE,
   input  logic [3:0]       ALUFlagsE,
   output logic             PCSrcE,
   output logic             FlushD,
   output logic             FlushE,
   output logic [3:0]       FlagsOut,
   output logic             UndefBranch,
   output logic             Busy,
   output logic [CNT_W-1:0] TakenCount,
   output logic [CNT_W-1:0] NotTakenCount
);

   localparam int RW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [RW-1:0] REM_INIT = RW'(FLUSH_CYCLES - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [RW-1:0]    r_remaining;
   logic [3:0]       r_flags;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_not_taken_cnt;

   logic w_act;
   logic w_resolve;
   logic w_cond_taken;
   logic w_cond_undef;
   logic w_taken;
   logic w_not_taken;

   // Gating with rst keeps the combinational outputs at 0 while reset is held.
   assign w_act       = rst & ValidE & ~StallE & (r_state == IDLE);
   assign w_resolve   = w_act & BranchE;
   assign w_taken     = w_resolve & w_cond_taken;
   assign w_not_taken = w_resolve & ~w_cond_taken;

   cond_eval u_cond_eval (
      .i_opcode (OpcodeE),
      .i_flag_n (r_flags[FLAG_N]),
      .i_flag_z (r_flags[FLAG_Z]),
      .i_flag_v (r_flags[FLAG_V]),
      .o_taken  (w_cond_taken),
      .o_undef  (w_cond_undef)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      PCSrcE       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      UndefBranch  = 1'b0;
      Busy         = 1'b0;
      case (r_state)
         IDLE: begin
            PCSrcE      = w_taken;
            FlushD      = w_taken;
            FlushE      = w_taken;
            UndefBranch = w_resolve & w_cond_undef;
            if (w_taken && (FLUSH_CYCLES > 1)) begin
               w_next_state = FLUSH;
            end
         end
         FLUSH: begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            Busy   = 1'b1;
            if (!StallE && (r_remaining == RW'(1))) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Remaining flush cycles after the resolve cycle; frozen while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_remaining <= '0;
      end else if (r_state == IDLE) begin
         if (w_taken) begin
            r_remaining <= REM_INIT;
         end
      end else if (!StallE) begin
         r_remaining <= r_remaining - RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flags <= 4'b0000;
      end else if (w_act && FlagWriteE) begin
         r_flags <= ALUFlagsE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_taken_cnt     <= '0;
         r_not_taken_cnt <= '0;
      end else begin
         if (w_taken && (r_taken_cnt != '1)) begin
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
         end
         if (w_not_taken && (r_not_taken_cnt != '1)) begin
            r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
         end
      end
   end

   assign FlagsOut      = r_flags;
   assign TakenCount    = r_taken_cnt;
   assign NotTakenCount = r_not_taken_cnt;

endmodule

// File: tb/tb_branch_flag_controller.sv
// Randomized and directed bench for branch_flag_controller; a default-width
// instance and a narrow-counter instance share one stimulus stream.
module tb_branch_flag_controller;

   localparam int FC   = 2;
   localparam int W_A  = 16;
   localparam int W_B  = 4;

   logic clk;
   logic rst;
   logic StallE, ValidE, BranchE, FlagWriteE;
   logic [5:0] OpcodeE;
   logic [3:0] ALUFlagsE;

   logic           pcsrc_a, flushd_a, flushe_a, undef_a, busy_a;
   logic [3:0]     flags_a;
   logic [W_A-1:0] tcnt_a, ncnt_a;
   logic           pcsrc_b, flushd_b, flushe_b, undef_b, busy_b;
   logic [3:0]     flags_b;
   logic [W_B-1:0] tcnt_b, ncnt_b;

   int n_checks;
   int n_errors;

   // reference model state
   logic [3:0] m_flags;
   int         m_flush_rem;
   int         m_taken;
   int         m_not_taken;

   branch_flag_controller #(.FLUSH_CYCLES(FC), .CNT_W(W_A)) u_dut_a (
      .clk(clk), .rst(rst), .StallE(StallE), .ValidE(ValidE), .BranchE(BranchE),
      .FlagWriteE(FlagWriteE), .OpcodeE(OpcodeE), .ALUFlagsE(ALUFlagsE),
      .PCSrcE(pcsrc_a), .FlushD(flushd_a), .FlushE(flushe_a), .FlagsOut(flags_a),
      .UndefBranch(undef_a), .Busy(busy_a), .TakenCount(tcnt_a), .NotTakenCount(ncnt_a)
   );

   branch_flag_controller #(.FLUSH_CYCLES(FC), .CNT_W(W_B)) u_dut_b (
      .clk(clk), .rst(rst), .StallE(StallE), .ValidE(ValidE), .BranchE(BranchE),
      .FlagWriteE(FlagWriteE), .OpcodeE(OpcodeE), .ALUFlagsE(ALUFlagsE),
      .PCSrcE(pcsrc_b), .FlushD(flushd_b), .FlushE(flushe_b), .FlagsOut(flags_b),
      .UndefBranch(undef_b), .Busy(busy_b), .TakenCount(tcnt_b), .NotTakenCount(ncnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_reset();
      m_flags     = 4'b0000;
      m_flush_rem = 0;
      m_taken     = 0;
      m_not_taken = 0;
   endtask

   // Compares both instances against the model for the current cycle's
   // inputs, then advances the model across the coming clock edge.
   task automatic model_step();
      logic busy, act, br, cond, und, tk;
      busy = (m_flush_rem > 0);
      act  = ValidE && !StallE && !busy;
      br   = act && BranchE;
      cond = 1'b1;
      und  = 1'b0;
      if (OpcodeE[5:2] == 4'b0011) begin
         case (OpcodeE[1:0])
            2'd0: cond = m_flags[2];
            2'd1: begin cond = 1'b0; und = 1'b1; end
            2'd2: cond = !m_flags[2] && (m_flags[3] == m_flags[0]);
            default: cond = 1'b1;
         endcase
      end
      tk = br && cond;

      check("pcsrc_a",  32'(pcsrc_a),  32'(tk));
      check("flushd_a", 32'(flushd_a), 32'(busy || tk));
      check("flushe_a", 32'(flushe_a), 32'(busy || tk));
      check("undef_a",  32'(undef_a),  32'(br && und));
      check("busy_a",   32'(busy_a),   32'(busy));
      check("flags_a",  32'(flags_a),  32'(m_flags));
      check("tcnt_a",   32'(tcnt_a),   32'(sat(m_taken, W_A)));
      check("ncnt_a",   32'(ncnt_a),   32'(sat(m_not_taken, W_A)));
      check("pcsrc_b",  32'(pcsrc_b),  32'(tk));
      check("flushd_b", 32'(flushd_b), 32'(busy || tk));
      check("busy_b",   32'(busy_b),   32'(busy));
      check("tcnt_b",   32'(tcnt_b),   32'(sat(m_taken, W_B)));
      check("ncnt_b",   32'(ncnt_b),   32'(sat(m_not_taken, W_B)));

      if (busy) begin
         if (!StallE) m_flush_rem--;
      end else begin
         if (tk) begin
            m_taken++;
            m_flush_rem = FC - 1;
         end else if (br) begin
            m_not_taken++;
         end
         if (act && FlagWriteE) m_flags = ALUFlagsE;
      end
   endtask

   task automatic step(input logic v, input logic s, input logic b, input logic fw,
                       input logic [5:0] op, input logic [3:0] alu);
      @(negedge clk);
      ValidE = v; StallE = s; BranchE = b; FlagWriteE = fw;
      OpcodeE = op; ALUFlagsE = alu;
      #1;
      model_step();
   endtask

   task automatic idle_inputs();
      ValidE = 1'b0; StallE = 1'b0; BranchE = 1'b0; FlagWriteE = 1'b0;
      OpcodeE = 6'd0; ALUFlagsE = 4'd0;
   endtask

   initial begin
      logic [5:0] op;
      n_checks = 0;
      n_errors = 0;
      model_reset();
      idle_inputs();
      rst = 1'b0;
      #12;
      check("rst_pcsrc", 32'(pcsrc_a), 32'd0);
      check("rst_flush", 32'(flushd_a | flushe_a), 32'd0);
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_flags", 32'(flags_a), 32'd0);
      check("rst_tcnt",  32'(tcnt_a), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(0, 0, 0, 0, 6'd0, 4'd0);

      // flags Z, then BEQ taken with a two-cycle flush
      step(1, 0, 0, 1, 6'b000000, 4'b0100);
      step(1, 0, 1, 0, 6'b001100, 4'b0000);
      check("beq_pcsrc", 32'(pcsrc_a), 32'd1);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      check("beq_flush2", 32'(flushd_a), 32'd1);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      check("beq_flush_end", 32'(flushd_a), 32'd0);
      check("beq_tcnt", 32'(tcnt_a), 32'd1);

      // BGT taken with N=V, then not taken with N!=V
      step(1, 0, 0, 1, 6'b000000, 4'b1001);
      step(1, 0, 1, 0, 6'b001110, 4'b0000);
      check("bgt_taken", 32'(pcsrc_a), 32'd1);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      step(1, 0, 0, 1, 6'b000000, 4'b1000);
      step(1, 0, 1, 0, 6'b001110, 4'b0000);
      check("bgt_not_taken", 32'(pcsrc_a | flushd_a), 32'd0);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      check("bgt_ncnt", 32'(ncnt_a), 32'd1);

      // undefined condition
      step(1, 0, 1, 0, 6'b001101, 4'b0000);
      check("und_pulse", 32'(undef_a), 32'd1);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      check("und_end", 32'(undef_a), 32'd0);
      check("und_ncnt", 32'(ncnt_a), 32'd2);

      // stall held through FLUSH with a branch presented while busy
      step(1, 0, 1, 0, 6'b001111, 4'b0000);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 6'b001111, 4'b1111);
      check("stall_busy", 32'(busy_a), 32'd1);
      step(1, 0, 1, 1, 6'b001111, 4'b1111);
      step(0, 0, 0, 0, 6'd0, 4'd0);
      check("stall_done", 32'(busy_a), 32'd0);
      check("stall_ignored", 32'(tcnt_a), 32'd3);

      // asynchronous reset in the middle of FLUSH
      step(1, 0, 1, 1, 6'b001111, 4'b0110);
      @(posedge clk);
      #2;
      idle_inputs();
      rst = 1'b0;
      #1;
      check("arst_busy",  32'(busy_a), 32'd0);
      check("arst_flush", 32'(flushd_a | flushe_a | pcsrc_a), 32'd0);
      check("arst_flags", 32'(flags_a), 32'd0);
      check("arst_tcnt",  32'(tcnt_a), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      step(1, 0, 1, 0, 6'b001111, 4'b0000);
      check("bal_after_rst", 32'(pcsrc_a), 32'd1);

      // random traffic; also drives the narrow counters into saturation
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) op = {4'b0011, 2'($urandom_range(0, 3))};
         else op = 6'($urandom_range(0, 63));
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
              op, 4'($urandom_range(0, 15)));
      end
      check("sat_b_tcnt", 32'(tcnt_b), 32'(sat(m_taken, W_B)));
      check("sat_b_reached", 32'(m_taken > 15), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_flag_controller.md
# branch_flag_controller

Sequences conditional execution in the execute stage. It holds the architectural NZCV flag register and resolves branch opcodes against it. On a taken branch it drives the PC-select and sequences a multi-cycle front-end flush. It sits beside the execute-stage ALU and feeds the hazard/fetch logic. It also keeps saturating taken/not-taken counters for performance debug.

## Interface
- FLUSH_CYCLES, 2: cycles FlushD/FlushE stay asserted per taken branch (≥1)
- CNT_W, 16: width of each performance counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- StallE  in  1  execute stage frozen this cycle
- ValidE  in  1  execute-stage instruction is real (not a bubble)
- BranchE  in  1  execute-stage instruction is a branch
- FlagWriteE  in  1  execute-stage instruction updates flags
- OpcodeE  in  6  execute-stage opcode
- ALUFlagsE  in  4  ALU result flags {N,Z,C,V}
- PCSrcE  out  1  select branch target this cycle
- FlushD  out  1  flush decode register
- FlushE  out  1  flush execute register
- FlagsOut  out  4  current flag register {N,Z,C,V}
- UndefBranch  out  1  one-cycle pulse: branch with undefined condition resolved
- Busy  out  1  flush sequence in progress (state FLUSH)
- TakenCount  out  CNT_W  saturating taken-branch count
- NotTakenCount  out  CNT_W  saturating not-taken-branch count

## Operation
- Reset: flags=0000, state IDLE, counters 0; all outputs 0.
- Qualified instruction: `act = ValidE & ~StallE & (state==IDLE)`.
- Condition evaluation on registered flags (N=bit3, Z=bit2, C=bit1, V=bit0). It applies only for OpcodeE[5:2]==4'b0011:
  - 00 EQ: Z.
  - 01: undefined; never taken; UndefBranch=1.
  - 10 GT: ~Z & (N==V).
  - 11 AL: 1.
- A branch whose OpcodeE[5:2]≠0011 is treated as AL.
- Resolution: if `act & BranchE`:
  - taken → PCSrcE=1, FlushD=1, FlushE=1, TakenCount++.
  - else → NotTakenCount++.
- Counters saturate at all-ones.
- Flag write: if `act & FlagWriteE`, flags←ALUFlagsE at clock edge. A branch with FlagWriteE set evaluates old flags and still writes the new ones.
- FSM:
  - IDLE → FLUSH on a taken resolution when FLUSH_CYCLES>1, loading remaining=FLUSH_CYCLES-1. Otherwise stay IDLE.
  - FLUSH: FlushD=FlushE=1, Busy=1, PCSrcE=0. Instructions are ignored (no resolution, no flag write, no counting).
  - FLUSH: remaining decrements each non-stalled cycle. Moving remaining 1→0 returns to IDLE.
  - StallE in FLUSH holds remaining; flush outputs stay asserted.
- Stall in IDLE: no resolution, no flag write, outputs 0.

## Timing
- PCSrcE, first-cycle FlushD/FlushE, and UndefBranch are combinational from inputs and registered flags, valid in the resolve cycle T.
- Flush outputs are asserted cycles T..T+FLUSH_CYCLES-1 (absent stalls), then deasserted.
- Flag update is visible on FlagsOut at T+1. A branch at T+1 sees flags written at T (no bypass needed).
- Counters update at the edge ending T.
- Async reset mid-FLUSH: immediate return to IDLE, all outputs 0, flags cleared.
- Back-to-back taken branches are impossible. The second is flushed and ignored while Busy.

## Structure
- Shared package `cond_pkg`:
  - condition encodings COND_EQ=2'b00, COND_UND=2'b01, COND_GT=2'b10, COND_AL=2'b11.
  - BRANCH_CLASS=4'b0011.
  - Flag bit indices.
  - State enum {IDLE, FLUSH}.
- One sub-module, `cond_eval` (combinational opcode+flags → taken, undef), is natural.
- Flag register, FSM, flush counter and performance counters live in the top.

## Test plan
- Reset then idle → all outputs 0, FlagsOut=0000, counters 0.
- FlagWriteE with ALUFlagsE=0100, next cycle BEQ (001100) → PCSrcE=1 same cycle; FlushD/FlushE high 2 cycles; TakenCount=1.
- Flags 1001 (N=1,V=1,Z=0), BGT (001110) → taken. Then flags 1000, BGT → not taken, NotTakenCount=1, no flush.
- Opcode 001101 → UndefBranch pulses 1 cycle, not taken, NotTakenCount increments.
- Taken branch, StallE high for 3 cycles during FLUSH → flush held for 3 extra cycles. Branch presented while Busy is ignored.
- rst low mid-FLUSH → outputs 0 asynchronously; after release a BAL (001111) resolves normally. Counter preset near saturation stays at 0xFFFF.
